// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state type and reset defaults for the fetch unit.
// IFETCH_ALIGN_CHK_EN enables the S_FAULT misaligned-redirect path.
package ifetch_pkg;

    localparam logic [31:0] IFETCH_RESET_PC   = 32'h0000_016C;
    localparam int unsigned IFETCH_INSN_BYTES = 4;

    typedef enum logic [2:0] {
        S_ADDR,
        S_STROBE,
        S_CAPTURE,
        S_HOLD,
        S_FAULT
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_pc_reg.sv
// ifetch_pc_reg: fetch address register.
// Redirect load wins over sequential increment.
module ifetch_pc_reg
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFETCH_RESET_PC,
    parameter int unsigned INSN_BYTES = IFETCH_INSN_BYTES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    input  logic        load,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + INSN_BYTES;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: 4-phase ROM fetch with valid/ready hold and redirect.
// IFETCH_ALIGN_CHK_EN adds fetch_fault and the S_FAULT state.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFETCH_RESET_PC,
    parameter int unsigned INSN_BYTES = IFETCH_INSN_BYTES
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] rom_addr,
    output logic        rom_cs,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    output logic        fetch_fault
`endif
);

    ifetch_state_e state_q, state_d;
    logic          pc_inc;
    logic          pc_load;
    logic          capture;
    logic          bad_redirect;
    logic [31:0]   rpc;
    logic [31:0]   pc;

`ifdef IFETCH_ALIGN_CHK_EN
    assign rpc          = redirect_pc;
    assign bad_redirect = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign rpc          = redirect_pc & ~32'h3;
    assign bad_redirect = 1'b0;
`endif

    ifetch_pc_reg #(
        .RESET_PC   (RESET_PC),
        .INSN_BYTES (INSN_BYTES)
    ) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (pc_inc),
        .load    (pc_load),
        .load_pc (rpc),
        .pc      (pc)
    );

    // pc is a register, so the ROM address is registered and
    // only moves on the edge that leaves S_HOLD or on a redirect.
    assign rom_addr = pc;

    always_comb begin
        state_d = state_q;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        capture = 1'b0;
        if (bad_redirect) begin
            state_d = S_FAULT;
        end else if (redirect) begin
            pc_load = 1'b1;
            state_d = S_ADDR;
        end else begin
            unique case (state_q)
                S_ADDR:    state_d = S_STROBE;
                S_STROBE:  state_d = S_CAPTURE;
                S_CAPTURE: begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        pc_inc  = 1'b1;
                        state_d = S_ADDR;
                    end
                end
                S_FAULT:   state_d = S_FAULT;
                default:   state_d = S_ADDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_ADDR;
            rom_cs     <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
        end else begin
            state_q    <= state_d;
            rom_cs     <= (state_d == S_STROBE);
            inst_valid <= (state_d == S_HOLD);
            if (capture) begin
                inst    <= rom_data;
                inst_pc <= pc;
            end
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_fault <= 1'b0;
        end else begin
            fetch_fault <= (state_d == S_FAULT);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus randomized run
// against a latency-based reference model of the fetch unit.
module tb_instr_fetch;

    localparam logic [31:0] RPC0 = 32'h0000_016C;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rom_addr;
    logic        rom_cs;
    logic [31:0] rom_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef IFETCH_ALIGN_CHK_EN
    logic        fetch_fault;
`endif

    int nchk = 0;
    int nerr = 0;
    int rom_cnt = 0;
    bit watch_stale = 1'b0;
    bit stale_seen = 1'b0;

    // reference model state
    logic [31:0] mpc;
    int          age;
    bit          mfault;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rom_addr    (rom_addr),
        .rom_cs      (rom_cs),
        .rom_data    (rom_data),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IFETCH_ALIGN_CHK_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_016C: return 32'h0000_0093;
            32'h0000_0170: return 32'h0000_0113;
            32'h0000_0174: return 32'h0000_0193;
            32'h0000_0178: return 32'h0020_0193;
            32'h0000_017C: return 32'h00FF_07B7;
            32'h0000_0184: return 32'h0000_2097;
            default:       return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic bit goes_fault(input logic [31:0] r);
`ifdef IFETCH_ALIGN_CHK_EN
        return r[1:0] != 2'b00;
`else
        return 1'b0 & (r[1:0] != 2'b00);
`endif
    endfunction

    always @(posedge clk) begin
        if (rom_cs) begin
            rom_data <= rom_word(rom_addr);
            rom_cnt  <= rom_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (watch_stale && inst_valid && inst == 32'h00FF_07B7)
            stale_seen = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mpc    = RPC0;
        age    = 0;
        mfault = 1'b0;
    endtask

    // fetch timeline: address phase at age 0, strobe at 1,
    // instruction offered from age 3 until accepted
    task automatic model_edge();
        if (redirect) begin
            if (goes_fault(redirect_pc)) begin
                mfault = 1'b1;
            end else begin
                mfault = 1'b0;
                mpc    = redirect_pc & ~32'h3;
                age    = 0;
            end
        end else if (!mfault) begin
            if (age == 3) begin
                if (inst_ready) begin
                    mpc = mpc + 32'd4;
                    age = 0;
                end
            end else begin
                age++;
            end
        end
    endtask

    task automatic compare();
        if (mfault) begin
            chk("fault_rom_cs", {31'h0, rom_cs}, 32'h0);
            chk("fault_valid", {31'h0, inst_valid}, 32'h0);
`ifdef IFETCH_ALIGN_CHK_EN
            chk("fault_flag", {31'h0, fetch_fault}, 32'h1);
`endif
        end else begin
            chk("m_rom_addr", rom_addr, mpc);
            chk("m_rom_cs", {31'h0, rom_cs}, {31'h0, age == 1});
            chk("m_valid", {31'h0, inst_valid}, {31'h0, age == 3});
            if (age == 3) begin
                chk("m_inst", inst, rom_word(mpc));
                chk("m_inst_pc", inst_pc, mpc);
            end
`ifdef IFETCH_ALIGN_CHK_EN
            chk("m_fault_clr", {31'h0, fetch_fault}, 32'h0);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run_to_valid(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = inst_valid;
        end
        chk(nm, {31'h0, got}, 32'h1);
    endtask

    typedef struct {
        logic        cs;
        logic        vld;
        logic [31:0] addr;
        logic [31:0] ipc;
        logic [31:0] ins;
    } vec_t;

    function automatic vec_t mk(input logic cs, input logic vld,
                                input logic [31:0] addr,
                                input logic [31:0] ipc,
                                input logic [31:0] ins);
        vec_t v;
        v.cs   = cs;
        v.vld  = vld;
        v.addr = addr;
        v.ipc  = ipc;
        v.ins  = ins;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        logic [31:0] h_inst;
        logic [31:0] h_pc;
        int          h_cnt;

        tbl[0]  = mk(1, 0, 32'h16C, 0, 0);
        tbl[1]  = mk(0, 0, 32'h16C, 0, 0);
        tbl[2]  = mk(0, 1, 32'h16C, 32'h16C, 32'h0000_0093);
        tbl[3]  = mk(0, 0, 32'h170, 0, 0);
        tbl[4]  = mk(1, 0, 32'h170, 0, 0);
        tbl[5]  = mk(0, 0, 32'h170, 0, 0);
        tbl[6]  = mk(0, 1, 32'h170, 32'h170, 32'h0000_0113);
        tbl[7]  = mk(0, 0, 32'h174, 0, 0);
        tbl[8]  = mk(1, 0, 32'h174, 0, 0);
        tbl[9]  = mk(0, 0, 32'h174, 0, 0);
        tbl[10] = mk(0, 1, 32'h174, 32'h174, 32'h0000_0193);
        tbl[11] = mk(0, 0, 32'h178, 0, 0);
        tbl[12] = mk(1, 0, 32'h178, 0, 0);
        tbl[13] = mk(0, 0, 32'h178, 0, 0);
        tbl[14] = mk(0, 1, 32'h178, 32'h178, 32'h0020_0193);
        tbl[15] = mk(0, 0, 32'h17C, 0, 0);
        tbl[16] = mk(1, 0, 32'h17C, 0, 0);

        // reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", rom_addr, RPC0);
        chk("rst_rom_cs", {31'h0, rom_cs}, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
`ifdef IFETCH_ALIGN_CHK_EN
        chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // streaming table from reset with inst_ready held high
        inst_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            chk($sformatf("tbl%0d_cs", i), {31'h0, rom_cs}, {31'h0, tbl[i].cs});
            chk($sformatf("tbl%0d_vld", i), {31'h0, inst_valid},
                {31'h0, tbl[i].vld});
            chk($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].addr);
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_ipc", i), inst_pc, tbl[i].ipc);
                chk($sformatf("tbl%0d_ins", i), inst, tbl[i].ins);
            end
        end

        // redirect while 0x17C is strobed: its data must never show
        watch_stale = 1'b1;
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h184;
        step();
        chk("redir_addr", rom_addr, 32'h184);
        chk("redir_valid", {31'h0, inst_valid}, 32'h0);
        redirect = 1'b0;
        run_to_valid("redir_timeout");
        chk("redir_inst", inst, 32'h0000_2097);
        chk("redir_inst_pc", inst_pc, 32'h184);
        watch_stale = 1'b0;
        chk("stale_presented", {31'h0, stale_seen}, 32'h0);

        // backpressure: 10 cycles held, no ROM traffic
        h_inst = inst;
        h_pc   = inst_pc;
        h_cnt  = rom_cnt;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_inst", inst, h_inst);
            chk("hold_pc", inst_pc, h_pc);
            chk("hold_cs", {31'h0, rom_cs}, 32'h0);
        end
        chk("hold_rom_accesses", rom_cnt, h_cnt);
        inst_ready = 1'b1;
        step();
        chk("after_hold_addr", rom_addr, 32'h188);

        // pc wrap at the top of the address space
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        run_to_valid("wrap_timeout");
        inst_ready = 1'b1;
        step();
        chk("wrap_addr", rom_addr, 32'h0);

        // redirect coincident with accept: redirect target wins
        inst_ready = 1'b0;
        run_to_valid("coinc_timeout");
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        chk("coinc_addr", rom_addr, 32'h200);
        chk("coinc_valid", {31'h0, inst_valid}, 32'h0);
        redirect = 1'b0;

        // reset asserted while strobing aborts at once
        inst_ready = 1'b0;
        step();
        chk("pre_rst_cs", {31'h0, rom_cs}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cs", {31'h0, rom_cs}, 32'h0);
        chk("mid_rst_addr", rom_addr, RPC0);
        chk("mid_rst_inst", inst, 32'h0);
        #1;
        reset_n = 1'b1;
        model_reset();
        run_to_valid("post_rst_timeout");
        chk("post_rst_inst", inst, 32'h0000_0093);
        chk("post_rst_pc", inst_pc, RPC0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = {20'h0, 12'($urandom_range(0, 12'hFFF))};
            step();
        end
        redirect = 1'b0;

`ifdef IFETCH_ALIGN_CHK_EN
        redirect    = 1'b1;
        redirect_pc = 32'h186;
        step();
        chk("fault_set", {31'h0, fetch_fault}, 32'h1);
        redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("fault_stuck_cs", {31'h0, rom_cs}, 32'h0);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h188;
        step();
        chk("fault_clear", {31'h0, fetch_fault}, 32'h0);
        chk("fault_resume_addr", rom_addr, 32'h188);
        redirect = 1'b0;
        run_to_valid("fault_resume_timeout");
        chk("fault_resume_pc", inst_pc, 32'h188);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000016C: fetch address loaded at reset.
REQ-002 Parameter INSN_BYTES, default 4: PC increment per accepted instruction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 rom_addr  output  32  byte address presented to the code ROM.
REQ-006 rom_cs  output  1  ROM strobe; the ROM latches rom_data on its rising edge.
REQ-007 rom_data  input  32  instruction word returned by the ROM.
REQ-008 inst_valid  output  1  inst and inst_pc hold a fetched instruction.
REQ-009 inst  output  32  fetched instruction word.
REQ-010 inst_pc  output  32  address inst was fetched from.
REQ-011 inst_ready  input  1  consumer accepts inst this cycle.
REQ-012 redirect  input  1  branch/jump redirect request, single-cycle pulse or level.
REQ-013 redirect_pc  input  32  new fetch address when redirect=1.
REQ-014 fetch_fault  output  1  misaligned-redirect fault; exists only with IFETCH_ALIGN_CHK_EN.

Function
REQ-015 FSM states: S_ADDR, S_STROBE, S_CAPTURE, S_HOLD, plus S_FAULT with IFETCH_ALIGN_CHK_EN.
REQ-016 S_ADDR: rom_addr=pc, rom_cs=0; next state S_STROBE.
REQ-017 S_STROBE: rom_addr unchanged, rom_cs=1; next state S_CAPTURE.
REQ-018 S_CAPTURE: rom_cs=0; inst<=rom_data, inst_pc<=pc, inst_valid<=1; next state S_HOLD.
REQ-019 Latency: first inst_valid=1 three cycles after the fetch enters S_ADDR.
REQ-020 S_HOLD: inst, inst_pc, inst_valid stable while inst_ready=0.
REQ-021 S_HOLD with inst_ready=1: handshake completes; inst_valid<=0; pc<=pc+INSN_BYTES; next state S_ADDR.
REQ-022 pc arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0 with no flag.
REQ-023 rom_cs and rom_addr are registered outputs; rom_addr never changes while rom_cs=1.
REQ-024 redirect=1 in any state has priority over all other transitions: pc<=redirect_pc, inst_valid<=0, rom_cs<=0, next state S_ADDR.
REQ-025 redirect coincident with inst_ready=1 in S_HOLD: the held instruction counts as consumed; pc takes redirect_pc, not pc+4.
REQ-026 redirect during S_STROBE or S_CAPTURE: in-flight ROM data is discarded, never presented.
REQ-027 Back-to-back redirects: the last one wins; each restarts S_ADDR.
REQ-028 Sustained throughput: one instruction per 4 cycles with inst_ready held at 1.

Reset
REQ-029 reset_n low: pc=RESET_PC, state=S_ADDR, rom_cs=0, rom_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_fault=0.
REQ-030 Reset asserted mid-fetch aborts immediately; first post-reset fetch is from RESET_PC.

Configuration
REQ-031 Macro IFETCH_ALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_fault=1, enters S_FAULT; S_FAULT drives rom_cs=0 and inst_valid=0.
REQ-032 With the macro, S_FAULT exits only on reset or an aligned redirect, which clears fetch_fault and enters S_ADDR.
REQ-033 Without the macro, fetch_fault port is absent and redirect_pc[1:0] is forced to 2'b00.

Structure
REQ-034 Package ifetch_pkg holds the state enum, INSN_BYTES default and the RESET_PC default constant.
REQ-035 One sub-module, ifetch_pc_reg: pc register with reset load, increment and redirect load.

Verification
REQ-036 Reset release, ROM[0x16C]=32'h00000093, inst_ready=1 -> rom_addr=0x16C, inst_valid=1 on cycle 3 with inst=32'h00000093, inst_pc=0x16C.
REQ-037 inst_ready=0 for 10 cycles in S_HOLD -> inst/inst_pc stable, rom_cs stays 0, no new ROM access.
REQ-038 Streaming from 0x16C with inst_ready=1 -> inst_pc 0x16C,0x170,0x174,0x178 every 4 cycles; inst 0x00000093,0x00000113,0x00000193,0x00200193.
REQ-039 redirect to 0x184 during S_STROBE of 0x17C -> 32'h00FF07B7 never presented; next inst=32'h00002097, inst_pc=0x184.
REQ-040 pc=0xFFFFFFFC accepted -> next rom_addr=0x00000000.
REQ-041 IFETCH_ALIGN_CHK_EN, redirect_pc=0x186 -> fetch_fault=1, rom_cs=0 indefinitely; redirect_pc=0x188 -> fetch_fault=0, fetch resumes at 0x188.
